// File: rtl/contador_checker.sv
// contador_checker: self-checking monitor for the 4-bit modal counter.
// A shadow model of the counter is anchored by the first parallel load and
// then compared cycle-by-cycle against the counter's Q/RCO. Mismatches are
// flagged, counted, and the first failing sample is captured.
module contador_checker #(
  parameter int CNT_W       = 8,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             RCO,
  output logic             SYNCED,
  output logic             ERR,
  output logic             ERR_STICKY,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] RCO_CNT,
  output logic [4:0]       FIRST_OBS,
  output logic [4:0]       FIRST_EXP
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t           state_r;
  state_t           state_s;
  logic [3:0]       exp_q_r;
  logic [3:0]       exp_q_s;
  logic             exp_rco_r;
  logic             exp_rco_s;
  logic             load_s;
  logic             mismatch_s;
  logic             synced_s;
  logic             err_s;
  logic             sticky_s;
  logic [CNT_W-1:0] err_cnt_s;
  logic [CNT_W-1:0] rco_cnt_s;
  logic [4:0]       first_obs_s;
  logic [4:0]       first_exp_s;

  // Saturating increment: counters stop at all-ones and never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Load detection and compare; case-inequality makes X/Z on Q or RCO a mismatch.
  always_comb begin
    load_s     = ENB && (MODO == 2'b11);
    mismatch_s = 1'b0;
    if (state_r == ST_CHECK) begin
      mismatch_s = (Q !== exp_q_r) || (RCO !== exp_rco_r);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Shadow counter model: anchors on a load in SYNC, tracks the counter in CHECK.
  always_comb begin
    exp_q_s   = exp_q_r;
    exp_rco_s = exp_rco_r;
    case (state_r)
      ST_SYNC: begin
        if (load_s) begin
          exp_q_s   = D;
          exp_rco_s = 1'b0;
        end else begin
          exp_q_s   = exp_q_r;
          exp_rco_s = exp_rco_r;
        end
      end
      ST_CHECK: begin
        if (ENB) begin
          case (MODO)
            2'b00: begin
              exp_q_s   = exp_q_r + 4'd1;
              exp_rco_s = (exp_q_r == 4'hF);
            end
            2'b01: begin
              exp_q_s   = exp_q_r - 4'd1;
              exp_rco_s = (exp_q_r == 4'h0);
            end
            2'b10: begin
              exp_q_s   = exp_q_r - 4'd3;
              exp_rco_s = 1'b0;
            end
            2'b11: begin
              exp_q_s   = D;
              exp_rco_s = 1'b0;
            end
            default: begin
              exp_q_s   = exp_q_r;
              exp_rco_s = exp_rco_r;
            end
          endcase
        end else begin
          exp_q_s   = exp_q_r;
          exp_rco_s = exp_rco_r;
        end
      end
      default: begin
        exp_q_s   = exp_q_r;
        exp_rco_s = exp_rco_r;
      end
    endcase
  end

  // Next-state logic: only RESET leaves HALTED.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_SYNC: begin
        if (load_s) begin
          state_s = ST_CHECK;
        end else begin
          state_s = ST_SYNC;
        end
      end
      ST_CHECK: begin
        if (mismatch_s && HALT_ON_ERR) begin
          state_s = ST_HALTED;
        end else begin
          state_s = ST_CHECK;
        end
      end
      ST_HALTED: state_s = ST_HALTED;
      default:   state_s = ST_SYNC;
    endcase
  end

  // State and model registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r   <= ST_SYNC;
      exp_q_r   <= 4'h0;
      exp_rco_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      exp_q_r   <= exp_q_s;
      exp_rco_r <= exp_rco_s;
    end
  end

  // Next values of the reporting outputs; HALTED freezes everything.
  always_comb begin
    synced_s    = (state_s == ST_CHECK);
    err_s       = 1'b0;
    sticky_s    = ERR_STICKY;
    err_cnt_s   = ERR_CNT;
    rco_cnt_s   = RCO_CNT;
    first_obs_s = FIRST_OBS;
    first_exp_s = FIRST_EXP;
    if (state_r == ST_CHECK) begin
      if (mismatch_s) begin
        err_s     = 1'b1;
        sticky_s  = 1'b1;
        err_cnt_s = sat_inc(ERR_CNT);
        if (!ERR_STICKY) begin
          first_obs_s = {RCO, Q};
          first_exp_s = {exp_rco_r, exp_q_r};
        end else begin
          first_obs_s = FIRST_OBS;
          first_exp_s = FIRST_EXP;
        end
      end else begin
        err_s     = 1'b0;
        err_cnt_s = ERR_CNT;
      end
      if (RCO === 1'b1) begin
        rco_cnt_s = sat_inc(RCO_CNT);
      end else begin
        rco_cnt_s = RCO_CNT;
      end
    end else begin
      err_s     = 1'b0;
      rco_cnt_s = RCO_CNT;
    end
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SYNCED     <= 1'b0;
      ERR        <= 1'b0;
      ERR_STICKY <= 1'b0;
      ERR_CNT    <= {CNT_W{1'b0}};
      RCO_CNT    <= {CNT_W{1'b0}};
      FIRST_OBS  <= 5'h00;
      FIRST_EXP  <= 5'h00;
    end else begin
      SYNCED     <= synced_s;
      ERR        <= err_s;
      ERR_STICKY <= sticky_s;
      ERR_CNT    <= err_cnt_s;
      RCO_CNT    <= rco_cnt_s;
      FIRST_OBS  <= first_obs_s;
      FIRST_EXP  <= first_exp_s;
    end
  end

endmodule

// File: tb/tb_contador_checker.sv
// Testbench for contador_checker: three instances (default, halt-on-error,
// 2-bit counters) share one stimulus stream. A directed vector table, a few
// hand sequences and a randomized phase are checked against a behavioural model.
module tb_contador_checker;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENB = 1'b0;
  logic [1:0] MODO = 2'b00;
  logic [3:0] D = 4'h0;
  logic [3:0] Q = 4'h0;
  logic       RCO = 1'b0;

  logic       syn_a, err_a, stk_a;
  logic [7:0] ecnt_a, rcnt_a;
  logic [4:0] fo_a, fe_a;
  logic       syn_h, err_h, stk_h;
  logic [7:0] ecnt_h, rcnt_h;
  logic [4:0] fo_h, fe_h;
  logic       syn_s, err_s, stk_s;
  logic [1:0] ecnt_s, rcnt_s;
  logic [4:0] fo_s, fe_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  contador_checker dut_a (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO),
    .SYNCED(syn_a), .ERR(err_a), .ERR_STICKY(stk_a), .ERR_CNT(ecnt_a),
    .RCO_CNT(rcnt_a), .FIRST_OBS(fo_a), .FIRST_EXP(fe_a));

  contador_checker #(.CNT_W(8), .HALT_ON_ERR(1'b1)) dut_h (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO),
    .SYNCED(syn_h), .ERR(err_h), .ERR_STICKY(stk_h), .ERR_CNT(ecnt_h),
    .RCO_CNT(rcnt_h), .FIRST_OBS(fo_h), .FIRST_EXP(fe_h));

  contador_checker #(.CNT_W(2), .HALT_ON_ERR(1'b0)) dut_s (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .D(D), .Q(Q), .RCO(RCO),
    .SYNCED(syn_s), .ERR(err_s), .ERR_STICKY(stk_s), .ERR_CNT(ecnt_s),
    .RCO_CNT(rcnt_s), .FIRST_OBS(fo_s), .FIRST_EXP(fe_s));

  // Behavioural model of one checker. st: 0 waiting for anchor, 1 checking, 2 halted.
  typedef struct {
    int st; int eq; int er; int err; int stk; int ecnt; int rcnt; int fo; int fe;
  } mdl_t;

  mdl_t m [3];
  int   halt_cfg [3] = '{0, 1, 0};
  int   max_cfg  [3] = '{255, 255, 3};

  // Free-running counter that supplies realistic Q/RCO (it has no reset).
  int ctr_q = 9;
  int ctr_r = 0;

  function automatic mdl_t mstep(mdl_t c, int halt, int maxc, int rst, int enb,
                                 int modo, int d, int q, int rco);
    mdl_t n;
    n = c;
    n.err = 0;
    if (rst != 0) begin
      n = '{default: 0};
      return n;
    end
    if (c.st == 0) begin
      if (enb != 0 && modo == 3) begin
        n.eq = d; n.er = 0; n.st = 1;
      end
    end else if (c.st == 1) begin
      if (q != c.eq || rco != c.er) begin
        n.err  = 1;
        n.ecnt = (c.ecnt < maxc) ? c.ecnt + 1 : maxc;
        if (c.stk == 0) begin
          n.fo = rco * 16 + q;
          n.fe = c.er * 16 + c.eq;
        end
        n.stk = 1;
        if (halt != 0) n.st = 2;
      end
      if (rco == 1) n.rcnt = (c.rcnt < maxc) ? c.rcnt + 1 : maxc;
      if (enb != 0) begin
        case (modo)
          0: begin n.eq = (c.eq + 1) % 16;  n.er = (c.eq == 15) ? 1 : 0; end
          1: begin n.eq = (c.eq + 15) % 16; n.er = (c.eq == 0) ? 1 : 0; end
          2: begin n.eq = (c.eq + 13) % 16; n.er = 0; end
          default: begin n.eq = d; n.er = 0; end
        endcase
      end
    end
    return n;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_inst(string t, int i, logic syn, logic err, logic stk,
                            int ecnt, int rcnt, int fo, int fe);
    chk({t, "_synced"}, int'(syn), (m[i].st == 1) ? 1 : 0);
    chk({t, "_err"}, int'(err), m[i].err);
    chk({t, "_sticky"}, int'(stk), m[i].stk);
    chk({t, "_err_cnt"}, ecnt, m[i].ecnt);
    chk({t, "_rco_cnt"}, rcnt, m[i].rcnt);
    chk({t, "_first_obs"}, fo, m[i].fo);
    chk({t, "_first_exp"}, fe, m[i].fe);
  endtask

  // One clock: drive inputs, advance models at the edge, compare on the falling edge.
  task automatic cycle(bit rst, bit enb, logic [1:0] modo, logic [3:0] d,
                       logic [3:0] q, bit rco);
    RESET = rst; ENB = enb; MODO = modo; D = d; Q = q; RCO = rco;
    @(posedge CLK);
    for (int i = 0; i < 3; i++)
      m[i] = mstep(m[i], halt_cfg[i], max_cfg[i], int'(rst), int'(enb),
                   int'(modo), int'(d), int'(q), int'(rco));
    if (enb) begin
      case (modo)
        2'b00: begin ctr_r = (ctr_q == 15) ? 1 : 0; ctr_q = (ctr_q + 1) % 16; end
        2'b01: begin ctr_r = (ctr_q == 0) ? 1 : 0;  ctr_q = (ctr_q + 15) % 16; end
        2'b10: begin ctr_r = 0; ctr_q = (ctr_q + 13) % 16; end
        default: begin ctr_r = 0; ctr_q = int'(d); end
      endcase
    end
    @(negedge CLK);
    check_inst("a", 0, syn_a, err_a, stk_a, int'(ecnt_a), int'(rcnt_a), int'(fo_a), int'(fe_a));
    check_inst("h", 1, syn_h, err_h, stk_h, int'(ecnt_h), int'(rcnt_h), int'(fo_h), int'(fe_h));
    check_inst("s", 2, syn_s, err_s, stk_s, int'(ecnt_s), int'(rcnt_s), int'(fo_s), int'(fe_s));
  endtask

  typedef struct {
    bit rst; bit enb; logic [1:0] modo; logic [3:0] d; logic [3:0] q; bit rco;
    int syn; int err; int ecnt; int rcnt; int stk; int first;
  } vec_t;

  vec_t vq [$];

  task automatic v(bit rst, bit enb, logic [1:0] modo, logic [3:0] d, logic [3:0] q,
                   bit rco, int syn, int err, int ecnt, int rcnt, int stk, int first);
    vec_t e;
    e.rst = rst; e.enb = enb; e.modo = modo; e.d = d; e.q = q; e.rco = rco;
    e.syn = syn; e.err = err; e.ecnt = ecnt; e.rcnt = rcnt; e.stk = stk; e.first = first;
    vq.push_back(e);
  endtask

  initial begin
    // first-failure snapshot {FIRST_OBS,FIRST_EXP} = {5'h0B,5'h0C}
    int f1;
    f1 = (11 << 5) | 12;
    for (int i = 0; i < 3; i++) m[i] = '{default: 0};

    //  rst enb modo   d     q     rco | syn err ecnt rcnt stk first
    v(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)           // counting without a load: never synced
      v(1'b0, 1'b1, 2'd0, 4'h0, 4'(3 + k), 1'b0, 0, 0, 0, 0, 0, 0);
    v(1'b0, 1'b1, 2'd3, 4'hE, 4'h8, 1'b0, 1, 0, 0, 0, 0, 0);   // anchor on load E
    v(1'b0, 1'b1, 2'd0, 4'h0, 4'hE, 1'b0, 1, 0, 0, 0, 0, 0);
    v(1'b0, 1'b1, 2'd0, 4'h0, 4'hF, 1'b0, 1, 0, 0, 0, 0, 0);
    v(1'b0, 1'b1, 2'd0, 4'h0, 4'h0, 1'b1, 1, 0, 0, 1, 0, 0);   // wrap, RCO=1
    v(1'b0, 1'b1, 2'd3, 4'h2, 4'h1, 1'b0, 1, 0, 0, 1, 0, 0);   // load 2
    v(1'b0, 1'b1, 2'd2, 4'h0, 4'h2, 1'b0, 1, 0, 0, 1, 0, 0);
    v(1'b0, 1'b1, 2'd2, 4'h0, 4'hF, 1'b0, 1, 0, 0, 1, 0, 0);
    v(1'b0, 1'b0, 2'd0, 4'h0, 4'hB, 1'b0, 1, 1, 1, 1, 1, f1);  // B instead of C
    v(1'b0, 1'b0, 2'd0, 4'h0, 4'hC, 1'b0, 1, 0, 1, 1, 1, f1);
    v(1'b0, 1'b1, 2'd3, 4'h0, 4'hC, 1'b0, 1, 0, 1, 1, 1, f1);  // load 0
    for (int k = 0; k < 3; k++)           // enable low: hold
      v(1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 1'b0, 1, 0, 1, 1, 1, f1);
    v(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 1'b0, 1, 0, 1, 1, 1, f1);
    v(1'b0, 1'b0, 2'd1, 4'h0, 4'hF, 1'b1, 1, 0, 1, 2, 1, f1);
    v(1'b0, 1'b1, 2'd1, 4'h0, 4'hF, 1'b1, 1, 0, 1, 3, 1, f1);
    v(1'b0, 1'b1, 2'd1, 4'h0, 4'hE, 1'b0, 1, 0, 1, 3, 1, f1);
    v(1'b0, 1'b1, 2'd3, 4'h5, 4'h9, 1'b0, 1, 1, 2, 3, 1, f1);  // mismatch + load
    v(1'b0, 1'b1, 2'd0, 4'h0, 4'h5, 1'b0, 1, 0, 2, 3, 1, f1);
    v(1'b0, 1'b1, 2'd0, 4'h0, 4'h6, 1'b1, 1, 1, 3, 4, 1, f1);  // bad RCO only
    v(1'b0, 1'b1, 2'd0, 4'h0, 4'h7, 1'b0, 1, 0, 3, 4, 1, f1);
    v(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 0, 0, 0, 0, 0, 0);   // reset clears all

    foreach (vq[i]) begin
      cycle(vq[i].rst, vq[i].enb, vq[i].modo, vq[i].d, vq[i].q, vq[i].rco);
      chk("tbl_synced", int'(syn_a), vq[i].syn);
      chk("tbl_err", int'(err_a), vq[i].err);
      chk("tbl_err_cnt", int'(ecnt_a), vq[i].ecnt);
      chk("tbl_rco_cnt", int'(rcnt_a), vq[i].rcnt);
      chk("tbl_sticky", int'(stk_a), vq[i].stk);
      chk("tbl_first", int'({fo_a, fe_a}), vq[i].first);
    end

    // Halt-on-error: two bad samples, only the first is counted.
    cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    cycle(1'b0, 1'b1, 2'd3, 4'h3, 4'h0, 1'b0);
    cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'h7, 1'b0);
    chk("halt_err_first", int'(err_h), 1);
    cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'h7, 1'b0);
    chk("halt_err_cnt", int'(ecnt_h), 1);
    chk("halt_synced", int'(syn_h), 0);
    chk("halt_err_second", int'(err_h), 0);
    chk("nohalt_err_cnt", int'(ecnt_a), 2);
    cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'h7, 1'b0);
    chk("halt_rst_outs", int'({syn_h, err_h, stk_h, ecnt_h, rcnt_h, fo_h, fe_h}), 0);

    // Saturation of a 2-bit error counter.
    cycle(1'b0, 1'b1, 2'd3, 4'h3, 4'h0, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'h7, 1'b0);
    chk("sat_err_cnt", int'(ecnt_s), 3);
    chk("sat_sticky", int'(stk_s), 1);
    chk("sat_first_obs", int'(fo_s), 5'h07);
    chk("sat_first_exp", int'(fe_s), 5'h03);
    chk("wide_err_cnt", int'(ecnt_a), 5);
    cycle(1'b0, 1'b0, 2'd0, 4'h0, 4'h7, 1'b0);
    chk("sat_err_cnt_hold", int'(ecnt_s), 3);

    // Randomized phase: real counter output with occasional corruption.
    cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      bit         r_rst, r_enb, r_rco;
      logic [1:0] r_modo;
      logic [3:0] r_d, r_q;
      r_rst  = ($urandom_range(0, 149) == 0);
      r_enb  = ($urandom_range(0, 3) != 0);
      r_modo = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_d    = 4'($urandom_range(0, 15));
      r_q    = 4'(ctr_q);
      r_rco  = (ctr_r != 0);
      if ($urandom_range(0, 24) == 0) r_q = r_q ^ 4'($urandom_range(1, 15));
      if ($urandom_range(0, 49) == 0) r_rco = ~r_rco;
      cycle(r_rst, r_enb, r_modo, r_d, r_q, r_rco);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
